// File: rtl/aabb_hit_pipe_pkg.sv
// aabb_hit_pipe_pkg: shared ray/box/hit types and Q16.16 fixed-point helpers
// for the AABB intersector and the BVH traversal unit.
package aabb_hit_pipe_pkg;
    localparam int FX_W    = 32;
    localparam int FX_FRAC = 16;
    localparam int VI_W    = 16;

    typedef logic signed [FX_W-1:0] fixed_t;
    typedef fixed_t [2:0] vec3_t;
    typedef logic [VI_W-1:0] voxel_index_t;
    typedef logic [2:0][1:0] normal_t;

    localparam voxel_index_t NULL_VOXEL_INDEX = '1;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef enum logic [1:0] {ST_NONE, ST_DIFFUSE, ST_METAL, ST_EMISSIVE} surface_type_t;

    typedef struct packed {
        vec3_t        orig;
        vec3_t        inv_dir;
        vec3_t        dir;
        fixed_t       min_t;
        fixed_t       max_t;
        voxel_index_t vi;
    } ray_t;

    typedef struct packed {
        vec3_t lo;
        vec3_t hi;
    } aabb_t;

    typedef struct packed {
        logic          b_hit;
        fixed_t        t;
        voxel_index_t  vi;
        rgb8_t         color;
        surface_type_t st;
        normal_t       normal;
    } hit_data_t;

    typedef struct packed {
        logic       b_hit;
        fixed_t     t;
        logic [2:0] lane;
    } lane_result_t;

    typedef struct packed {
        fixed_t       min_t;
        fixed_t       max_t;
        voxel_index_t vi;
    } ray_lim_t;

    typedef struct packed {
        voxel_index_t  vi;
        rgb8_t         color;
        surface_type_t st;
    } lane_attr_t;

    localparam hit_data_t HIT_NONE = '{b_hit: 1'b0, t: '0, vi: NULL_VOXEL_INDEX,
                                       color: '0, st: ST_NONE, normal: '0};

    function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
        logic signed [2*FX_W-1:0] p;
        p = (2*FX_W)'(a) * (2*FX_W)'(b);
        return FX_W'(p >>> FX_FRAC);
    endfunction

    function automatic fixed_t fx_min(input fixed_t a, input fixed_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic fixed_t fx_max(input fixed_t a, input fixed_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/aabb_hit_pipe_lane_slab.sv
// aabb_lane_slab: combinational per-lane hit test on the slab interval,
// applying empty-lane, self-voxel and ray T-range rejection.
module aabb_lane_slab
    import aabb_hit_pipe_pkg::*;
#(
    parameter int LANE = 0
) (
    input  fixed_t       min_t,
    input  fixed_t       max_t,
    input  voxel_index_t vi,
    input  ray_lim_t     ray,
    output lane_result_t res
);
    fixed_t hit_t;

    // Origin inside the box reports the exit face.
    always_comb begin
        hit_t = (min_t > 0) ? min_t : max_t;
        res.b_hit = !vi[VI_W-1] && (vi != ray.vi) && (min_t < max_t) && (max_t > 0) &&
                    (ray.max_t[FX_W-1] ||
                     ($signed(ray.min_t) <= hit_t && hit_t <= $signed(ray.max_t)));
        res.t = hit_t;
        res.lane = 3'(LANE);
    end
endmodule

// File: rtl/aabb_hit_pipe.sv
// aabb_hit_pipe: 4-stage multi-lane ray/AABB slab intersector, closest-hit reduction.
// AABB_PIPE_NORMAL_EN adds the winning lane's face normal to out_hit.
module aabb_hit_pipe
    import aabb_hit_pipe_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int TAG_W  = 8,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          in_tag,
    input  ray_t                      in_ray,
    input  aabb_t [LANES-1:0]         in_aabb,
    input  voxel_index_t [LANES-1:0]  in_vi,
    input  rgb8_t [LANES-1:0]         in_color,
    input  surface_type_t [LANES-1:0] in_st,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output hit_data_t                 out_hit,
    output logic [LANE_W-1:0]         out_lane
);
    logic adv;
    logic v1, v2, v3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    ray_lim_t lim1, lim2, lim3;
    vec3_t inv1;
    lane_attr_t [LANES-1:0] la_in, la1, la2, la3;
    vec3_t [LANES-1:0] d0_1, d1_1, t0_2, t1_2;
    fixed_t [LANES-1:0] lmin3, lmax3;
    lane_result_t [LANES-1:0] lr;
    lane_result_t best;
    lane_attr_t win_attr;
    hit_data_t hit_nx;
    logic unused_lane;

    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign unused_lane = ^best.lane;

    always_comb begin
        la_in = '0;
        for (int i = 0; i < LANES; i++)
            la_in[i] = '{vi: in_vi[i], color: in_color[i], st: in_st[i]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) {v1, v2, v3} <= '0;
        else if (adv) {v1, v2, v3} <= {in_valid, v1, v2};
    end

`ifdef AABB_PIPE_NORMAL_EN
    vec3_t dir1, dir2, dir3;
    vec3_t [LANES-1:0] t0_3, t1_3;
    vec3_t win_t0, win_t1;

    always_ff @(posedge clk) begin
        if (adv) begin
            dir1 <= in_ray.dir;
            dir2 <= dir1;
            dir3 <= dir2;
            t0_3 <= t0_2;
            t1_3 <= t1_2;
        end
    end
`else
    logic unused_dir;
    assign unused_dir = ^in_ray.dir;
`endif

    always_ff @(posedge clk) begin
        if (adv) begin
            tag1 <= in_tag;
            tag2 <= tag1;
            tag3 <= tag2;
            lim1 <= '{min_t: in_ray.min_t, max_t: in_ray.max_t, vi: in_ray.vi};
            lim2 <= lim1;
            lim3 <= lim2;
            inv1 <= in_ray.inv_dir;
            la1 <= la_in;
            la2 <= la1;
            la3 <= la2;
            for (int i = 0; i < LANES; i++) begin
                for (int a = 0; a < 3; a++) begin
                    d0_1[i][a] <= in_aabb[i].lo[a] - in_ray.orig[a];
                    d1_1[i][a] <= in_aabb[i].hi[a] - in_ray.orig[a];
                    t0_2[i][a] <= fixed_mul(d0_1[i][a], inv1[a]);
                    t1_2[i][a] <= fixed_mul(d1_1[i][a], inv1[a]);
                end
                lmin3[i] <= fx_max(fx_max(fx_min(t0_2[i][0], t1_2[i][0]),
                                          fx_min(t0_2[i][1], t1_2[i][1])),
                                   fx_min(t0_2[i][2], t1_2[i][2]));
                lmax3[i] <= fx_min(fx_min(fx_max(t0_2[i][0], t1_2[i][0]),
                                          fx_max(t0_2[i][1], t1_2[i][1])),
                                   fx_max(t0_2[i][2], t1_2[i][2]));
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aabb_lane_slab #(.LANE(i)) u_slab (
            .min_t(lmin3[i]),
            .max_t(lmax3[i]),
            .vi   (la3[i].vi),
            .ray  (lim3),
            .res  (lr[i])
        );
    end

    // Strict less-than while scanning upward keeps the lowest lane on equal T.
    always_comb begin
        best = '0;
        win_attr = '0;
`ifdef AABB_PIPE_NORMAL_EN
        win_t0 = '0;
        win_t1 = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (lr[i].b_hit && (!best.b_hit || $signed(lr[i].t) < $signed(best.t))) begin
                best = lr[i];
                win_attr = la3[i];
`ifdef AABB_PIPE_NORMAL_EN
                win_t0 = t0_3[i];
                win_t1 = t1_3[i];
`endif
            end
        end
        hit_nx.b_hit = best.b_hit;
        hit_nx.t = best.b_hit ? best.t : '0;
        hit_nx.vi = best.b_hit ? win_attr.vi : NULL_VOXEL_INDEX;
        hit_nx.color = win_attr.color;
        hit_nx.st = win_attr.st;
        hit_nx.normal = '0;
`ifdef AABB_PIPE_NORMAL_EN
        for (int a = 0; a < 3; a++)
            hit_nx.normal[a] = !best.b_hit ? 2'b00 :
                               (best.t == win_t0[a] && $signed(dir3[a]) > 0) ? 2'b11 :
                               (best.t == win_t1[a] && $signed(dir3[a]) < 0) ? 2'b01 : 2'b00;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_hit <= HIT_NONE;
            out_lane <= '0;
            out_tag <= '0;
        end else if (adv) begin
            out_valid <= v3;
            if (v3) begin
                out_hit <= hit_nx;
                out_lane <= best.lane[LANE_W-1:0];
                out_tag <= tag3;
            end
        end
    end
endmodule

// File: tb/tb_aabb_hit_pipe.sv
// tb_aabb_hit_pipe: directed vector table plus streaming/backpressure and
// mid-flight reset sequences for aabb_hit_pipe.
module tb_aabb_hit_pipe;
    import aabb_hit_pipe_pkg::*;

    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int NV = 12;
    localparam fixed_t INF = 32'sh2000_0000;
    localparam fixed_t UNB = 32'sh8000_0000;
    localparam normal_t N0 = 6'b00_00_00;
    localparam normal_t NZ_NEG = 6'b11_00_00;
    localparam normal_t NX_POS = 6'b00_00_01;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [TAG_W-1:0] in_tag = '0;
    ray_t in_ray = '0;
    aabb_t [LANES-1:0] in_aabb = '0;
    voxel_index_t [LANES-1:0] in_vi = '0;
    rgb8_t [LANES-1:0] in_color = '0;
    surface_type_t [LANES-1:0] in_st = '{default: ST_NONE};
    logic out_valid;
    logic out_ready = 1'b1;
    logic [TAG_W-1:0] out_tag;
    hit_data_t out_hit;
    logic [1:0] out_lane;

    always #5 clk = ~clk;

    aabb_hit_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tag   (in_tag),
        .in_ray   (in_ray),
        .in_aabb  (in_aabb),
        .in_vi    (in_vi),
        .in_color (in_color),
        .in_st    (in_st),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tag  (out_tag),
        .out_hit  (out_hit),
        .out_lane (out_lane)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic fixed_t fx(input int v);
        return fixed_t'(v * 65536);
    endfunction

    // Directions are restricted to -1/0/+1 so the reciprocal is exact.
    function automatic ray_t mk_ray(input int ox, input int oy, input int oz,
                                    input int dx, input int dy, input int dz,
                                    input fixed_t mn, input fixed_t mx, input voxel_index_t vi);
        ray_t r;
        int o[3];
        int d[3];
        o = '{ox, oy, oz};
        d = '{dx, dy, dz};
        for (int a = 0; a < 3; a++) begin
            r.orig[a] = fx(o[a]);
            r.dir[a] = fx(d[a]);
            r.inv_dir[a] = (d[a] == 0) ? INF : fx(d[a]);
        end
        r.min_t = mn;
        r.max_t = mx;
        r.vi = vi;
        return r;
    endfunction

    function automatic aabb_t mk_box(input int x0, input int y0, input int z0,
                                     input int x1, input int y1, input int z1);
        aabb_t b;
        b.lo[0] = fx(x0); b.lo[1] = fx(y0); b.lo[2] = fx(z0);
        b.hi[0] = fx(x1); b.hi[1] = fx(y1); b.hi[2] = fx(z1);
        return b;
    endfunction

    typedef struct {
        string        name;
        ray_t         ray;
        aabb_t        box[LANES];
        voxel_index_t vi[LANES];
        logic         e_hit;
        fixed_t       e_t;
        int           e_lane;
        voxel_index_t e_vi;
        normal_t      e_n;
    } vec_t;

    vec_t tv[NV];

    function automatic vec_t mk(input string nm, input ray_t r, input logic h, input int t,
                                input int lane, input normal_t n);
        vec_t v;
        v.name = nm;
        v.ray = r;
        for (int i = 0; i < LANES; i++) begin
            v.box[i] = mk_box(-1, -1, -1, 1, 1, 1);
            v.vi[i] = voxel_index_t'(16'h8000 + i);
        end
        v.e_hit = h;
        v.e_t = fx(t);
        v.e_lane = h ? lane : 0;
        v.e_vi = h ? voxel_index_t'(16'h0100 + lane) : NULL_VOXEL_INDEX;
        v.e_n = h ? n : N0;
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic [TAG_W-1:0] tg);
        in_ray = v.ray;
        in_tag = tg;
        for (int i = 0; i < LANES; i++) begin
            in_aabb[i] = v.box[i];
            in_vi[i] = v.vi[i];
            in_color[i] = '{r: 8'(i * 16 + 1), g: 8'h22, b: 8'h33};
            in_st[i] = ST_DIFFUSE;
        end
    endtask

    function automatic vec_t stream_beat(input int k);
        vec_t v;
        v = mk("stream", mk_ray(0, 0, -5 - k, 0, 0, 1, '0, UNB, 16'h0200), 1'b1, 4 + k, 0, NZ_NEG);
        v.vi[0] = voxel_index_t'(16'h0100 + k);
        return v;
    endfunction

    task automatic check_result(input vec_t v, input logic [TAG_W-1:0] tg);
        check({v.name, ".hit"}, out_hit.b_hit, v.e_hit);
        check({v.name, ".lane"}, out_lane, v.e_lane);
        check({v.name, ".vi"}, out_hit.vi, v.e_vi);
        check({v.name, ".tag"}, out_tag, tg);
        if (v.e_hit) begin
            check({v.name, ".t"}, out_hit.t, v.e_t);
            check({v.name, ".color"}, out_hit.color.r, 8'(v.e_lane * 16 + 1));
        end
`ifdef AABB_PIPE_NORMAL_EN
        check({v.name, ".normal"}, out_hit.normal, v.e_n);
`else
        check({v.name, ".normal"}, out_hit.normal, N0);
`endif
    endtask

    initial begin
        vec_t v;
        int sent, recv, extra;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        tv[0] = mk("basic", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 1, 4, 0, NZ_NEG);
        tv[0].vi[0] = 16'h0100;
        tv[1] = mk("skip_vi", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0102), 1, 4, 3, NZ_NEG);
        tv[1].box[1] = mk_box(-1, -1, 2, 1, 1, 3);
        tv[1].box[2] = mk_box(-1, -1, -3, 1, 1, -2);
        tv[1].vi[1] = 16'h0101; tv[1].vi[2] = 16'h0102; tv[1].vi[3] = 16'h0103;
        tv[2] = mk("tie", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 1, 4, 1, NZ_NEG);
        tv[2].vi[1] = 16'h0101; tv[2].vi[2] = 16'h0102;
        tv[3] = mk("inside", mk_ray(0, 0, 0, 0, 0, 1, '0, UNB, 16'h0200), 1, 1, 0, N0);
        tv[3].vi[0] = 16'h0100;
        tv[4] = mk("beyond_max", mk_ray(0, 0, -5, 0, 0, 1, '0, fx(3), 16'h0200), 0, 0, 0, N0);
        tv[4].vi[0] = 16'h0100;
        tv[5] = mk("at_max", mk_ray(0, 0, -5, 0, 0, 1, '0, fx(4), 16'h0200), 1, 4, 0, NZ_NEG);
        tv[5].vi[0] = 16'h0100;
        tv[6] = mk("behind", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 0, 0, 0, N0);
        tv[6].box[0] = mk_box(-1, -1, -10, 1, 1, -8);
        tv[6].vi[0] = 16'h0100;
        tv[7] = mk("neg_dir", mk_ray(5, 0, 0, -1, 0, 0, '0, UNB, 16'h0200), 1, 4, 0, NX_POS);
        tv[7].vi[0] = 16'h0100;
        tv[8] = mk("x_miss", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 0, 0, 0, N0);
        tv[8].box[0] = mk_box(2, -1, -1, 3, 1, 1);
        tv[8].vi[0] = 16'h0100;
        tv[9] = mk("closer_hi", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 1, 4, 1, NZ_NEG);
        tv[9].box[0] = mk_box(-1, -1, 2, 1, 1, 3);
        tv[9].vi[0] = 16'h0100; tv[9].vi[1] = 16'h0101;
        tv[10] = mk("below_min", mk_ray(0, 0, -5, 0, 0, 1, fx(5), fx(9), 16'h0200), 0, 0, 0, N0);
        tv[10].vi[0] = 16'h0100;
        tv[11] = mk("all_empty", mk_ray(0, 0, -5, 0, 0, 1, '0, UNB, 16'h0200), 0, 0, 0, N0);

        #2 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.valid", out_valid, 0);
        check("rst.hit", out_hit.b_hit, 0);
        check("rst.vi", out_hit.vi, NULL_VOXEL_INDEX);
        check("rst.lane", out_lane, 0);
        check("rst.tag", out_tag, 0);
        check("rst.in_ready", in_ready, 1);
        resetn = 1'b1;

        for (int n = 0; n < NV; n++) begin
            @(negedge clk);
            drive(tv[n], 8'(n + 1));
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #1 check({tv[n].name, ".early"}, out_valid, 0);
            @(negedge clk);
            #1 check({tv[n].name, ".valid"}, out_valid, 1);
            check_result(tv[n], 8'(n + 1));
        end

        sent = 0;
        recv = 0;
        for (int c = 0; c < 200 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = pat[c % 4];
            if (sent < 8) begin
                drive(stream_beat(sent), 8'(8'h40 + sent));
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                check("stream.tag", out_tag, 8'(8'h40 + recv));
                check("stream.t", out_hit.t, fx(4 + recv));
                check("stream.vi", out_hit.vi, 16'h0100 + recv);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("stream.count", recv, 8);
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 if (out_valid) extra++;
        end
        check("stream.no_dup", extra, 0);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(stream_beat(k), 8'(8'h60 + k));
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("flush.pre_valid", out_valid, 1);
        check("flush.pre_tag", out_tag, 8'h60);
        resetn = 1'b0;
        #1;
        check("flush.valid", out_valid, 0);
        check("flush.hit", out_hit.b_hit, 0);
        check("flush.vi", out_hit.vi, NULL_VOXEL_INDEX);
        check("flush.lane", out_lane, 0);
        check("flush.tag", out_tag, 0);
        @(negedge clk);
        resetn = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 if (out_valid) extra++;
        end
        check("flush.no_stale", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
